// File: rtl/demux_1x2_sched.sv
// Scheduler for the 1-to-2 demux path: routes each accepted word to one of two holding registers.
// Optional per-channel delivery counters are enabled with `DEMUX_SCHED_COUNT_EN.
module demux_1x2_sched #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_dest,
    input  logic              mode,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out2_valid,
    input  logic              out2_ready,
    output logic [DATA_W-1:0] out2_data,
`ifdef DEMUX_SCHED_COUNT_EN
    output logic [CNT_W-1:0]  count1,
    output logic [CNT_W-1:0]  count2,
`endif
    output logic              sel,
    output logic              e,
    output logic              state_dbg
);

    // Handshake: a word moves when valid & ready are both high at a rising edge;
    // ready never depends on valid, and a held output stays stable until taken.
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t state;
    logic   mode_q;
    logic   ptr;
    logic   free1;
    logic   free2;
    logic   load1;
    logic   load2;

    always_comb begin
        sel      = mode_q ? in_dest : ptr;
        // A full channel being drained this cycle can take a new word (pass-through refill).
        free1    = !out1_valid || out1_ready;
        free2    = !out2_valid || out2_ready;
        in_ready = (state == RUN) && (mode == mode_q) && (sel ? free2 : free1);
        e        = in_valid && in_ready;
        load1    = e && !sel;
        load2    = e && sel;
    end

    assign state_dbg = logic'(state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            mode_q     <= 1'b0;
            ptr        <= 1'b0;
            out1_valid <= 1'b0;
            out2_valid <= 1'b0;
            out1_data  <= '0;
            out2_data  <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mode != mode_q)
                        state <= FLUSH;
                end
                FLUSH: begin
                    // Mode is sampled only once both channels are empty, so a revert mid-flush is harmless.
                    if (!out1_valid && !out2_valid) begin
                        state  <= RUN;
                        mode_q <= mode;
                        ptr    <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase

            if (e && !mode_q)
                ptr <= ~ptr;

            if (load1) begin
                out1_data  <= in_data;
                out1_valid <= 1'b1;
            end else if (out1_valid && out1_ready) begin
                out1_valid <= 1'b0;
            end

            if (load2) begin
                out2_data  <= in_data;
                out2_valid <= 1'b1;
            end else if (out2_valid && out2_ready) begin
                out2_valid <= 1'b0;
            end
        end
    end

`ifdef DEMUX_SCHED_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count1 <= '0;
            count2 <= '0;
        end else begin
            if (load1)
                count1 <= count1 + 1'b1;
            if (load2)
                count2 <= count2 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_1x2_sched.sv
// Directed bench for demux_1x2_sched: vector table plus hand-written reset sequences.
module tb_demux_1x2_sched;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_dest;
    logic              mode;
    logic              out1_valid;
    logic              out1_ready;
    logic [DATA_W-1:0] out1_data;
    logic              out2_valid;
    logic              out2_ready;
    logic [DATA_W-1:0] out2_data;
    logic              sel;
    logic              e;
    logic              state_dbg;
`ifdef DEMUX_SCHED_COUNT_EN
    logic [CNT_W-1:0]  count1;
    logic [CNT_W-1:0]  count2;
`endif

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] exp1_q[$];
    logic [DATA_W-1:0] exp2_q[$];

    typedef struct {
        logic              iv;
        logic [DATA_W-1:0] d;
        logic              dest;
        logic              md;
        logic              r1;
        logic              r2;
        logic              x_ready;
        logic              x_sel;
        logic              x_e;
        logic              x_o1v;
        logic [DATA_W-1:0] x_o1d;
        logic              x_o2v;
        logic [DATA_W-1:0] x_o2d;
    } vec_t;

    vec_t vecs[$];

    demux_1x2_sched #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .mode      (mode),
        .out1_valid(out1_valid),
        .out1_ready(out1_ready),
        .out1_data (out1_data),
        .out2_valid(out2_valid),
        .out2_ready(out2_ready),
        .out2_data (out2_data),
`ifdef DEMUX_SCHED_COUNT_EN
        .count1    (count1),
        .count2    (count2),
`endif
        .sel       (sel),
        .e         (e),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [DATA_W-1:0] d, input logic dest,
                         input logic md, input logic r1, input logic r2);
        in_valid   = iv;
        in_data    = d;
        in_dest    = dest;
        mode       = md;
        out1_ready = r1;
        out2_ready = r2;
    endtask

    task automatic add(input logic iv, input logic [DATA_W-1:0] d, input logic dest, input logic md,
                       input logic r1, input logic r2, input logic xr, input logic xs, input logic xe,
                       input logic o1v, input logic [DATA_W-1:0] o1d,
                       input logic o2v, input logic [DATA_W-1:0] o2d);
        vec_t v;
        v.iv = iv; v.d = d; v.dest = dest; v.md = md; v.r1 = r1; v.r2 = r2;
        v.x_ready = xr; v.x_sel = xs; v.x_e = xe;
        v.x_o1v = o1v; v.x_o1d = o1d; v.x_o2v = o2v; v.x_o2d = o2d;
        vecs.push_back(v);
    endtask

    // Scoreboard: words leave a channel only in the order they were accepted for it.
    task automatic score_outputs();
        logic [DATA_W-1:0] w;
        if (out1_valid && out1_ready) begin
            if (exp1_q.size() == 0) check("out1_unexpected_word", 32'(out1_data), 32'hffff_ffff);
            else begin w = exp1_q.pop_front(); check("out1_scoreboard", 32'(out1_data), 32'(w)); end
        end
        if (out2_valid && out2_ready) begin
            if (exp2_q.size() == 0) check("out2_unexpected_word", 32'(out2_data), 32'hffff_ffff);
            else begin w = exp2_q.pop_front(); check("out2_scoreboard", 32'(out2_data), 32'(w)); end
        end
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;

        //   iv  data   dst md r1 r2  rdy sel e   o1v o1d    o2v o2d
        // round-robin, full rate
        add(1, 8'h11, 0, 0, 1, 1,  1, 0, 1,  1, 8'h11, 0, 8'h00);
        add(1, 8'h22, 0, 0, 1, 1,  1, 1, 1,  0, 8'h11, 1, 8'h22);
        add(1, 8'h33, 0, 0, 1, 1,  1, 0, 1,  1, 8'h33, 0, 8'h22);
        add(1, 8'h44, 0, 0, 1, 1,  1, 1, 1,  0, 8'h33, 1, 8'h44);
        add(0, 8'h00, 0, 0, 1, 1,  1, 0, 0,  0, 8'h33, 0, 8'h44);
        // round-robin, out2 backpressured: strict order, no skipping to free out1
        add(1, 8'hA1, 0, 0, 1, 0,  1, 0, 1,  1, 8'hA1, 0, 8'h44);
        add(1, 8'hA2, 0, 0, 1, 0,  1, 1, 1,  0, 8'hA1, 1, 8'hA2);
        add(1, 8'hA3, 0, 0, 1, 0,  1, 0, 1,  1, 8'hA3, 1, 8'hA2);
        add(1, 8'hA4, 0, 0, 1, 0,  0, 1, 0,  0, 8'hA3, 1, 8'hA2);
        add(1, 8'hA4, 0, 0, 1, 0,  0, 1, 0,  0, 8'hA3, 1, 8'hA2);
        add(1, 8'hA4, 0, 0, 1, 1,  1, 1, 1,  0, 8'hA3, 1, 8'hA4);
        add(0, 8'h00, 0, 0, 1, 1,  1, 0, 0,  0, 8'hA3, 0, 8'hA4);
        // mode 0 -> 1 while out1 holds AA and is stalled three cycles
        add(1, 8'hAA, 0, 0, 0, 1,  1, 0, 1,  1, 8'hAA, 0, 8'hA4);
        add(1, 8'hBB, 1, 1, 0, 1,  0, 1, 0,  1, 8'hAA, 0, 8'hA4);
        add(1, 8'hBB, 1, 1, 0, 1,  0, 1, 0,  1, 8'hAA, 0, 8'hA4);
        add(1, 8'hBB, 1, 1, 0, 1,  0, 1, 0,  1, 8'hAA, 0, 8'hA4);
        add(1, 8'hBB, 1, 1, 1, 1,  0, 1, 0,  0, 8'hAA, 0, 8'hA4);
        add(1, 8'hBB, 1, 1, 1, 1,  0, 1, 0,  0, 8'hAA, 0, 8'hA4);
        // addressed mode, three words to out2
        add(1, 8'hBB, 1, 1, 1, 1,  1, 1, 1,  0, 8'hAA, 1, 8'hBB);
        add(1, 8'hCC, 1, 1, 1, 1,  1, 1, 1,  0, 8'hAA, 1, 8'hCC);
        add(1, 8'hDD, 1, 1, 1, 1,  1, 1, 1,  0, 8'hAA, 1, 8'hDD);
        add(0, 8'h00, 1, 1, 1, 1,  1, 1, 0,  0, 8'hAA, 0, 8'hDD);

        // reset state
        #12;
        check("rst_out1_valid", 32'(out1_valid), 32'd0);
        check("rst_out2_valid", 32'(out2_valid), 32'd0);
        check("rst_out1_data", 32'(out1_data), 32'd0);
        check("rst_out2_data", 32'(out2_data), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_e", 32'(e), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
`ifdef DEMUX_SCHED_COUNT_EN
        check("rst_count1", 32'(count1), 32'd0);
        check("rst_count2", 32'(count2), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].dest, vecs[i].md, vecs[i].r1, vecs[i].r2);
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].x_ready));
            check($sformatf("v%0d_sel", i), 32'(sel), 32'(vecs[i].x_sel));
            check($sformatf("v%0d_e", i), 32'(e), 32'(vecs[i].x_e));
            score_outputs();
            if (vecs[i].x_e) begin
                if (vecs[i].x_sel) exp2_q.push_back(vecs[i].d);
                else exp1_q.push_back(vecs[i].d);
            end
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out1_valid", i), 32'(out1_valid), 32'(vecs[i].x_o1v));
            check($sformatf("v%0d_out1_data", i), 32'(out1_data), 32'(vecs[i].x_o1d));
            check($sformatf("v%0d_out2_valid", i), 32'(out2_valid), 32'(vecs[i].x_o2v));
            check($sformatf("v%0d_out2_data", i), 32'(out2_data), 32'(vecs[i].x_o2d));
            @(negedge clk);
        end
        check("out1_all_delivered", 32'(exp1_q.size()), 32'd0);
        check("out2_all_delivered", 32'(exp2_q.size()), 32'd0);
`ifdef DEMUX_SCHED_COUNT_EN
        check("count1_total", 32'(count1), 32'd5);
        check("count2_total", 32'(count2), 32'd7);
`endif

        // fill both channels in addressed mode, then reset mid-operation
        drive(1'b1, 8'hE1, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("fill_out1_valid", 32'(out1_valid), 32'd1);
        @(negedge clk);
        drive(1'b1, 8'hE2, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("fill_out2_valid", 32'(out2_valid), 32'd1);
        check("fill_out1_held", 32'(out1_data), 32'hE1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_out1_valid", 32'(out1_valid), 32'd0);
        check("midrst_out2_valid", 32'(out2_valid), 32'd0);
        check("midrst_out1_data", 32'(out1_data), 32'd0);
        check("midrst_out2_data", 32'(out2_data), 32'd0);
        check("midrst_state", 32'(state_dbg), 32'd0);
`ifdef DEMUX_SCHED_COUNT_EN
        check("midrst_count1", 32'(count1), 32'd0);
        check("midrst_count2", 32'(count2), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_sel", 32'(sel), 32'd0);
        @(posedge clk); #1;
        check("post_rst_out1_valid", 32'(out1_valid), 32'd0);
        check("post_rst_out2_valid", 32'(out2_valid), 32'd0);

        // first accept right after release lands on out1 one cycle later
        @(negedge clk);
        drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("post_rst_e", 32'(e), 32'd1);
        @(posedge clk); #1;
        check("post_rst_accept_valid", 32'(out1_valid), 32'd1);
        check("post_rst_accept_data", 32'(out1_data), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
